// File: rtl/pipeline_pkg.sv
// Shared types and constants for the instruction-fetch pipeline slice.
package pipeline_pkg;

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_PCWIDTH = 16;

    localparam logic [15:0] RESETPC_DEFAULT = 16'h0000;
    localparam logic [15:0] NOP_INSTR       = 16'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Plain-vector aliases of the fetch states for legacy state registers
    localparam logic [1:0] ST_FETCH = FETCH;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_HOLD  = HOLD;

endpackage

// File: rtl/fetch_stage_if.sv
// Request/response bus between the fetch stage and the instruction memory.
interface fetch_stage_if
    import pipeline_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned PCWIDTH = DEF_PCWIDTH
) ();

    logic               imemReq;
    logic [PCWIDTH-1:0] imemAddr;
    logic               imemReady;
    logic               imemValid;
    logic [WIDTH-1:0]   imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemReady,
        input  imemValid,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemReady,
        output imemValid,
        output imemData
    );

endinterface

// File: rtl/ifid_register.sv
// IF/ID pipeline register; priority flush > stall > load > bubble.
module ifid_register
    import pipeline_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned PCWIDTH = DEF_PCWIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               stall,
    input  logic               flush,
    input  logic [WIDTH-1:0]   instr_in,
    input  logic [PCWIDTH-1:0] pc_in,
    output logic [WIDTH-1:0]   instr,
    output logic [PCWIDTH-1:0] pc,
    output logic [PCWIDTH-1:0] pc_plus1,
    output logic               valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= WIDTH'(NOP_INSTR);
            pc       <= '0;
            pc_plus1 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= WIDTH'(NOP_INSTR);
            pc       <= '0;
            pc_plus1 <= '0;
            valid    <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                instr    <= instr_in;
                pc       <= pc_in;
                pc_plus1 <= pc_in + PCWIDTH'(1);
                valid    <= 1'b1;
            end else begin
                instr    <= WIDTH'(NOP_INSTR);
                pc       <= '0;
                pc_plus1 <= '0;
                valid    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding memory request FSM, branch squash
// and a one-entry hold buffer for responses that arrive while decode is stalled.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned        WIDTH   = DEF_WIDTH,
    parameter int unsigned        PCWIDTH = DEF_PCWIDTH,
    parameter logic [PCWIDTH-1:0] RESETPC = PCWIDTH'(RESETPC_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stallF,
    input  logic               stallD,
    input  logic               branchTakenE,
    input  logic [PCWIDTH-1:0] branchTargetE,
    fetch_stage_if.master      imem,
    output logic [WIDTH-1:0]   instrD,
    output logic [PCWIDTH-1:0] pcD,
    output logic [PCWIDTH-1:0] pcPlus1D,
    output logic               validD
);

    logic [1:0]         state_q, state_d;
    logic [PCWIDTH-1:0] pc_q, pc_d;
    logic [PCWIDTH-1:0] req_pc_q, req_pc_d;
    logic               squash_q, squash_d;
    logic [WIDTH-1:0]   hold_q, hold_d;

    logic               req_c;
    logic               ifid_load_c;
    logic [WIDTH-1:0]   ifid_instr_c;
    logic [PCWIDTH-1:0] req_pc_plus1_c;

    // Request is held low while in reset so the bus is quiet immediately.
    assign req_c          = reset && (state_q == ST_FETCH) && !stallF && !branchTakenE;
    assign req_pc_plus1_c = req_pc_q + PCWIDTH'(1);

    assign imem.imemReq  = req_c;
    assign imem.imemAddr = pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESETPC;
            req_pc_q <= '0;
            squash_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            squash_q <= squash_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        squash_d     = squash_q;
        hold_d       = hold_q;
        ifid_load_c  = 1'b0;
        ifid_instr_c = imem.imemData;

        case (state_q)
            ST_FETCH: begin
                if (branchTakenE) begin
                    pc_d = branchTargetE;
                end else if (req_c && imem.imemReady) begin
                    state_d  = ST_WAIT;
                    req_pc_d = pc_q;
                end
            end

            ST_WAIT: begin
                // A redirect with no response yet must swallow the later response.
                if (branchTakenE) begin
                    pc_d = branchTargetE;
                    if (imem.imemValid) begin
                        state_d  = ST_FETCH;
                        squash_d = 1'b0;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (imem.imemValid) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = ST_FETCH;
                    end else begin
                        pc_d = req_pc_plus1_c;
                        if (stallD) begin
                            hold_d  = imem.imemData;
                            state_d = ST_HOLD;
                        end else begin
                            ifid_load_c = 1'b1;
                            state_d     = ST_FETCH;
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (branchTakenE) begin
                    pc_d    = branchTargetE;
                    state_d = ST_FETCH;
                end else if (!stallD) begin
                    ifid_load_c  = 1'b1;
                    ifid_instr_c = hold_q;
                    state_d      = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    ifid_register #(
        .WIDTH   (WIDTH),
        .PCWIDTH (PCWIDTH)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (reset),
        .load     (ifid_load_c),
        .stall    (stallD),
        .flush    (branchTakenE),
        .instr_in (ifid_instr_c),
        .pc_in    (req_pc_q),
        .instr    (instrD),
        .pc       (pcD),
        .pc_plus1 (pcPlus1D),
        .valid    (validD)
    );

endmodule
